// File: rtl/button_evt_pkg.sv
// Shared types and default timing for the button event path.
// Event records, repeat-timer states and 25 MHz auto-repeat constants.
package button_evt_pkg;

    localparam int unsigned BTN_ID_W              = 3;
    localparam int unsigned BTN_HOLD_CYCLES_25M   = 12_500_000;
    localparam int unsigned BTN_REPEAT_CYCLES_25M = 2_500_000;

    typedef struct packed {
        logic [BTN_ID_W-1:0] id;
        logic                rpt;
    } btn_evt_t;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRpt
    } rpt_state_t;

endpackage

// File: rtl/button_repeat_timer.sv
// Per-button auto-repeat timer: first tick HOLD_CYCLES after the level rises,
// then one tick every REPEAT_CYCLES while the level stays high.
module button_repeat_timer
    import button_evt_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = BTN_HOLD_CYCLES_25M,
    parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_CYCLES_25M
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic tick
);

    localparam int unsigned MaxCyc = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    rpt_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (level) state_d = StHold;
            end
            StHold: begin
                if (!level) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
                    tick    = 1'b1;
                    cnt_d   = '0;
                    state_d = StRpt;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRpt: begin
                if (!level) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(REPEAT_CYCLES - 1)) begin
                    tick  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Merges button presses and auto-repeat ticks into one registered event channel
// with round-robin arbitration and sticky per-button lost-event flags.
module button_event_arbiter
    import button_evt_pkg::*;
#(
    parameter int unsigned      N_BTN         = 4,
    parameter int unsigned      HOLD_CYCLES   = BTN_HOLD_CYCLES_25M,
    parameter int unsigned      REPEAT_CYCLES = BTN_REPEAT_CYCLES_25M,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = {N_BTN{1'b1}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_pulse,
    input  logic [N_BTN-1:0]         btn_level,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_repeat,
    input  logic                     evt_ready,
    output logic [N_BTN-1:0]         ovf_flags,
    input  logic [N_BTN-1:0]         ovf_clr
);

    localparam int unsigned IdW = $clog2(N_BTN);

    logic [N_BTN-1:0] tick, new_evt, gnt_oh;
    logic [N_BTN-1:0] pend_q, pend_d, pend_rpt_q, pend_rpt_d, ovf_q, ovf_d;
    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d, gnt_idx, cand;
    logic             gnt_valid, slot_free;
    logic             evt_valid_q, evt_valid_d, evt_repeat_q, evt_repeat_d;
    logic [IdW-1:0]   evt_id_q, evt_id_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_timer
        if (REPEAT_MASK[i]) begin : g_on
            button_repeat_timer #(
                .HOLD_CYCLES  (HOLD_CYCLES),
                .REPEAT_CYCLES(REPEAT_CYCLES)
            ) u_timer (
                .clk  (clk),
                .rst  (rst),
                .level(btn_level[i]),
                .tick (tick[i])
            );
        end else begin : g_off
            assign tick[i] = 1'b0;
        end
    end

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        slot_free = ~evt_valid_q | evt_ready;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            cand = IdW'((32'(rr_ptr_q) + k) % N_BTN);
            if (!gnt_valid && pend_q[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt_valid = gnt_valid & slot_free;
        gnt_oh    = '0;
        if (gnt_valid) gnt_oh[gnt_idx] = 1'b1;
    end

    // A new event always wins over a same-cycle grant; a pulse outranks a tick.
    always_comb begin
        new_evt    = btn_pulse | tick;
        pend_d     = new_evt | (pend_q & ~gnt_oh);
        pend_rpt_d = (new_evt & ~btn_pulse) | (~new_evt & pend_rpt_q);
        ovf_d      = (new_evt & pend_q & ~gnt_oh) | (ovf_q & ~ovf_clr);
    end

    always_comb begin
        evt_valid_d  = evt_valid_q;
        evt_id_d     = evt_id_q;
        evt_repeat_d = evt_repeat_q;
        rr_ptr_d     = rr_ptr_q;
        if (gnt_valid) begin
            evt_valid_d  = 1'b1;
            evt_id_d     = gnt_idx;
            evt_repeat_d = pend_rpt_q[gnt_idx];
            rr_ptr_d     = (gnt_idx == IdW'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '0;
            pend_rpt_q   <= '0;
            ovf_q        <= '0;
            rr_ptr_q     <= '0;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            evt_repeat_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pend_rpt_q   <= pend_rpt_d;
            ovf_q        <= ovf_d;
            rr_ptr_q     <= rr_ptr_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            evt_repeat_q <= evt_repeat_d;
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_id     = evt_id_q;
    assign evt_repeat = evt_repeat_q;
    assign ovf_flags  = ovf_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with N_BTN=4, HOLD_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event_arbiter;
    import button_evt_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_pulse, btn_level, ovf_flags, ovf_clr;
    logic       evt_valid, evt_repeat, evt_ready;
    logic [1:0] evt_id;
    logic       exp_v;
    btn_evt_t   got_evt, exp_evt;
    int         n_chk  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .N_BTN        (4),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .REPEAT_MASK  (4'b1111)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pulse (btn_pulse),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_repeat(evt_repeat),
        .evt_ready (evt_ready),
        .ovf_flags (ovf_flags),
        .ovf_clr   (ovf_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_evt(input string tag, input logic [1:0] id, input logic rpt);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
        chk({tag, "_id"}, 32'(evt_id), 32'(id));
        chk({tag, "_rpt"}, 32'(evt_repeat), 32'(rpt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        btn_pulse = '0;
        btn_level = '0;
        evt_ready = 1'b0;
        ovf_clr   = '0;
        step();
        step();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_rpt", 32'(evt_repeat), 32'd0);
        chk("rst_ovf", 32'(ovf_flags), 32'd0);
        rst       = 1'b0;
        evt_ready = 1'b1;
        step();
        chk("idle_valid", 32'(evt_valid), 32'd0);

        // Simultaneous presses 0,1,3 from rr_ptr=0
        btn_pulse = 4'b1011;
        step();
        btn_pulse = '0;
        chk("sim_lat", 32'(evt_valid), 32'd0);
        step();
        chk_evt("sim_e0", 2'd0, 1'b0);
        step();
        chk_evt("sim_e1", 2'd1, 1'b0);
        step();
        chk_evt("sim_e3", 2'd3, 1'b0);
        step();
        chk("sim_drop", 32'(evt_valid), 32'd0);
        // rr_ptr wrapped to 0, so btn0 beats btn1
        btn_pulse = 4'b0011;
        step();
        btn_pulse = '0;
        step();
        chk_evt("rr_first", 2'd0, 1'b0);
        step();
        chk_evt("rr_second", 2'd1, 1'b0);
        step();
        chk("rr_drop", 32'(evt_valid), 32'd0);

        // Single press on btn2
        btn_pulse = 4'b0100;
        step();
        btn_pulse = '0;
        chk("single_lat", 32'(evt_valid), 32'd0);
        step();
        got_evt.id  = BTN_ID_W'(evt_id);
        got_evt.rpt = evt_repeat;
        exp_evt.id  = 3'd2;
        exp_evt.rpt = 1'b0;
        chk("single_valid", 32'(evt_valid), 32'd1);
        chk("single_evt", 32'(got_evt), 32'(exp_evt));
        step();
        chk("single_drop", 32'(evt_valid), 32'd0);

        // Auto-repeat: level on btn0 high for edges 0..20, press pulse at edge 0
        btn_level = 4'b0001;
        btn_pulse = 4'b0001;
        for (int k = 0; k <= 30; k++) begin
            step();
            btn_pulse = '0;
            btn_level = (k < 20) ? 4'b0001 : 4'b0000;
            exp_v     = (k == 1) || (k == 9) || (k == 13) || (k == 17) || (k == 21);
            chk($sformatf("rpt_valid_%0d", k), 32'(evt_valid), 32'(exp_v));
            if (exp_v) begin
                chk($sformatf("rpt_id_%0d", k), 32'(evt_id), 32'd0);
                chk($sformatf("rpt_type_%0d", k), 32'(evt_repeat), 32'(k != 1));
            end
        end

        // btn3 pulse lands on the cycle its pending press is granted
        btn_pulse = 4'b1000;
        step();
        chk("same_lat", 32'(evt_valid), 32'd0);
        step();
        btn_pulse = '0;
        chk_evt("same_first", 2'd3, 1'b0);
        chk("same_ovf_a", 32'(ovf_flags), 32'd0);
        step();
        chk_evt("same_second", 2'd3, 1'b0);
        chk("same_ovf_b", 32'(ovf_flags), 32'd0);
        step();
        chk("same_drop", 32'(evt_valid), 32'd0);

        // Stall with btn0 in the slot, btn1 pulsed twice 3 cycles apart
        evt_ready = 1'b0;
        btn_pulse = 4'b0001;
        step();
        btn_pulse = '0;
        step();
        chk_evt("stall_slot", 2'd0, 1'b0);
        btn_pulse = 4'b0010;
        step();
        btn_pulse = '0;
        chk("stall_ovf_pre", 32'(ovf_flags), 32'd0);
        step();
        step();
        btn_pulse = 4'b0010;
        step();
        btn_pulse = '0;
        chk("stall_ovf_set", 32'(ovf_flags), 32'h2);
        chk_evt("stall_hold", 2'd0, 1'b0);
        ovf_clr = 4'b0010;
        step();
        ovf_clr = '0;
        chk("stall_ovf_clr", 32'(ovf_flags), 32'd0);
        evt_ready = 1'b1;
        step();
        chk_evt("stall_next", 2'd1, 1'b0);
        step();
        chk("stall_drop", 32'(evt_valid), 32'd0);

        // Reset while an event is presented and btn2 is pending
        evt_ready = 1'b0;
        btn_pulse = 4'b0010;
        step();
        btn_pulse = 4'b0100;
        step();
        chk_evt("mid_slot", 2'd1, 1'b0);
        step();
        btn_pulse = '0;
        chk("mid_ovf", 32'(ovf_flags), 32'h4);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(evt_valid), 32'd0);
        chk("mid_rst_id", 32'(evt_id), 32'd0);
        chk("mid_rst_rpt", 32'(evt_repeat), 32'd0);
        chk("mid_rst_ovf", 32'(ovf_flags), 32'd0);
        rst       = 1'b0;
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post_rst_quiet_%0d", k), 32'(evt_valid), 32'd0);
        end
        // rr_ptr must be back at 0, so btn0 precedes btn2
        btn_pulse = 4'b0101;
        step();
        btn_pulse = '0;
        step();
        chk_evt("post_rst_a", 2'd0, 1'b0);
        step();
        chk_evt("post_rst_b", 2'd2, 1'b0);
        step();
        chk("post_rst_drop", 32'(evt_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
